tpu_host_seq: RTL and testbench

- Host-side initiator for the TPU memory-mapped slave port (r_w / addr / dataIn / dataOut).
- Takes a job as a valid/ready stream of 64-bit words and writes the A, B and C regions. It then issues the GO write, waits out the systolic latency, reads all C rows back, and emits them on a valid/ready output stream.
- Sits between a host command FIFO and the tpuv1 top; it is the only master on that port.

---
 rtl/tpu_host_seq_pkg.sv | 38 +++
 rtl/tpu_host_seq.sv | 219 +++++++++++++++++++++
 tb/tb_tpu_host_seq.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_host_seq_pkg.sv
// Shared definitions for the TPU host sequencer: bus map, word stride,
// FSM state encoding and region-size helpers.
package tpu_pkg;

  localparam int A_BASE      = 'h100;
  localparam int B_BASE      = 'h200;
  localparam int C_BASE      = 'h300;
  localparam int GO_ADDR     = 'h400;
  localparam int WORD_STRIDE = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_A,
    ST_LD_B,
    ST_LD_C,
    ST_GO,
    ST_WAIT,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_RD_OUT,
    ST_DONE
  } state_t;

  // Words needed for one A or B matrix (rows packed DATAW bits per word).
  function automatic int calc_nab(input int dim, input int bits_ab, input int dataw);
    return dim * bits_ab / dataw * dim;
  endfunction

  // Words needed for the C matrix.
  function automatic int calc_nc(input int dim, input int bits_c, input int dataw);
    return dim * bits_c / dataw * dim;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tpu_host_seq.sv
// Host-side master for the TPU slave port: loads A/B/C, fires GO, waits
// for the array to drain, then streams the C rows out.
// Build option: define TPU_HOST_C_PRELOAD_EN to take C accumulator seeds
// from the input stream; otherwise C is cleared with zero writes.
module tpu_host_seq
  import tpu_pkg::*;
#(
  parameter int DIM      = 8,
  parameter int BITS_AB  = 8,
  parameter int BITS_C   = 16,
  parameter int ADDRW    = 16,
  parameter int DATAW    = 64,
  parameter int WAIT_CYC = 3 * DIM,
  parameter int RD_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  localparam int NA    = calc_nab(DIM, BITS_AB, DATAW);
  localparam int NB    = NA;
  localparam int NC    = calc_nc(DIM, BITS_C, DATAW);
  localparam int CNT_W = $clog2(max2(NC, WAIT_CYC) + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] w_lat_nxt;
  logic [DATAW-1:0] r_out_data;
  logic             w_cap;
  logic [ADDRW-1:0] w_off;

  // Word offset inside the current region; the same counter indexes A, B and C.
  assign w_off = ADDRW'(r_cnt) * ADDRW'(WORD_STRIDE);

  // The result register is only visible while a word is being offered.
  assign out_data = (r_state == ST_RD_OUT) ? r_out_data : '0;

  // State, word counter and read-latency counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  // Capture the TPU read data once the read latency has elapsed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data <= '0;
    end else if (w_cap) begin
      r_out_data <= tpu_rdata;
    end
  end

  // Next-state and bus/handshake decode; the bus idles at address 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lat_nxt   = r_lat;
    w_cap       = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    tpu_r_w     = 1'b0;
    tpu_addr    = '0;
    tpu_wdata   = '0;

    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = ST_LD_A;
          w_cnt_nxt   = '0;
        end
      end

      ST_LD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tpu_r_w   = 1'b1;
          tpu_addr  = ADDRW'(A_BASE) + w_off;
          tpu_wdata = in_data;
          if (r_cnt == CNT_W'(NA - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_LD_B;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      ST_LD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tpu_r_w   = 1'b1;
          tpu_addr  = ADDRW'(B_BASE) + w_off;
          tpu_wdata = in_data;
          if (r_cnt == CNT_W'(NB - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_LD_C;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      ST_LD_C: begin
`ifdef TPU_HOST_C_PRELOAD_EN
        // Seeds come from the job stream under the same handshake as A/B.
        in_ready = 1'b1;
        if (in_valid) begin
          tpu_r_w   = 1'b1;
          tpu_addr  = ADDRW'(C_BASE) + w_off;
          tpu_wdata = in_data;
          if (r_cnt == CNT_W'(NC - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_GO;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
`else
        // Clear the accumulators back-to-back so the result is plain A x B.
        tpu_r_w  = 1'b1;
        tpu_addr = ADDRW'(C_BASE) + w_off;
        if (r_cnt == CNT_W'(NC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end

      ST_GO: begin
        tpu_r_w     = 1'b1;
        tpu_addr    = ADDRW'(GO_ADDR);
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        // The TPU ignores the port while computing, so stay off the bus.
        if (r_cnt == CNT_W'(WAIT_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RD_REQ;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_RD_REQ: begin
        tpu_addr    = ADDRW'(C_BASE) + w_off;
        w_lat_nxt   = '0;
        w_state_nxt = ST_RD_CAP;
      end

      ST_RD_CAP: begin
        // Keep the address stable until the data is captured.
        tpu_addr = ADDRW'(C_BASE) + w_off;
        if (r_lat == LAT_W'(RD_LAT - 1)) begin
          w_cap       = 1'b1;
          w_lat_nxt   = '0;
          w_state_nxt = ST_RD_OUT;
        end else begin
          w_lat_nxt = r_lat + LAT_W'(1);
        end
      end

      ST_RD_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (r_cnt == CNT_W'(NC - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = ST_RD_REQ;
          end
        end
      end

      ST_DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Testbench for tpu_host_seq: random jobs against a behavioural TPU and a
// matrix-product reference, with queued expectations checked by monitors.
module tb_tpu_host_seq;

  localparam int DIM      = 8;
  localparam int WAIT_CYC = 3 * DIM;
  localparam int RD_LAT   = 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        tpu_r_w;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_wdata;
  logic [63:0] tpu_rdata;

  tpu_host_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tpu_r_w   (tpu_r_w),
    .tpu_addr  (tpu_addr),
    .tpu_wdata (tpu_wdata),
    .tpu_rdata (tpu_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  // ---------------- job data and reference model ----------------
  logic [63:0] ja[8];
  logic [63:0] jb[8];
  logic [63:0] js[16];

  // C word w holds row w/2, columns 4*(w%2)..+3, 16 bits each, low column first.
  function automatic logic [63:0] ref_word(input int w);
    logic [63:0] r;
    logic [15:0] acc;
    int i, j;
    i = w / 2;
    r = 64'h0;
    for (int e = 0; e < 4; e++) begin
      j   = 4 * (w % 2) + e;
      acc = js[w][16*e +: 16];
      for (int k = 0; k < 8; k++)
        acc = acc + 16'(ja[i][8*k +: 8]) * 16'(jb[k][8*j +: 8]);
      r[16*e +: 16] = acc;
    end
    return r;
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [63:0] d;
  } wr_t;

  logic [63:0] exp_q[$];
  wr_t         wr_q[$];
  logic [15:0] rd_q[$];

  // ---------------- behavioural TPU ----------------
  int am[8][8];
  int bm[8][8];
  int cm[8][8];
  int ta;

  function automatic logic [63:0] pack_c(input int w);
    logic [63:0] r;
    for (int e = 0; e < 4; e++) r[16*e +: 16] = 16'(cm[w/2][4*(w%2)+e]);
    return r;
  endfunction

  always @(posedge clk) begin
    ta = int'(tpu_addr);
    if (tpu_r_w) begin
      if (ta >= 'h100 && ta < 'h140)
        for (int k = 0; k < 8; k++) am[(ta-'h100)/8][k] = int'(tpu_wdata[8*k +: 8]);
      else if (ta >= 'h200 && ta < 'h240)
        for (int k = 0; k < 8; k++) bm[(ta-'h200)/8][k] = int'(tpu_wdata[8*k +: 8]);
      else if (ta >= 'h300 && ta < 'h380)
        for (int e = 0; e < 4; e++)
          cm[(ta-'h300)/16][4*(((ta-'h300)/8)%2)+e] = int'(tpu_wdata[16*e +: 16]);
      else if (ta == 'h400)
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 8; k++) cm[i][j] = cm[i][j] + am[i][k] * bm[k][j];
            cm[i][j] = cm[i][j] & 'hFFFF;
          end
      tpu_rdata <= 64'h0;
    end else if (ta >= 'h300 && ta < 'h380) begin
      tpu_rdata <= pack_c((ta - 'h300) / 8);
    end else begin
      tpu_rdata <= 64'h0;
    end
  end

  // ---------------- monitors ----------------
  int          cyc = 0;
  int          done_cnt = 0;
  int          out_idx = 0;
  bit          hold_vld = 0;
  logic [63:0] hold_data;
  bit          go_arm = 0;
  int          go_cyc, act;
  int          rd_hold = 0;
  logic [15:0] rd_addr;
  wr_t         we;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 0;
      go_arm   = 0;
      rd_hold  = 0;
      out_idx  = 0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", 64'(busy), 64'd0);
        out_idx = 0;
      end
      // output stream: stability under backpressure, then scoreboard
      if (hold_vld) begin
        chk("out_hold_valid", 64'(out_valid), 64'd1);
        chk("out_hold_data", out_data, hold_data);
      end
      hold_vld  = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid) begin
        chk("bus_idle_while_out_valid", {47'd0, tpu_r_w, tpu_addr}, 64'd0);
        if (out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out_word", out_data, 64'hx);
          else chk("out_word", out_data, exp_q.pop_front());
          out_idx++;
        end
      end
      // GO-to-first-read window
      if (go_arm) begin
        if (!tpu_r_w && tpu_addr != 16'h0) begin
          chk("wait_cycles", 64'(cyc - go_cyc), 64'(WAIT_CYC + 1));
          chk("wait_bus_activity", 64'(act), 64'd0);
          go_arm = 0;
        end else if (tpu_r_w || tpu_addr != 16'h0) begin
          act++;
        end
      end
      // writes
      if (tpu_r_w) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write_addr", 64'(tpu_addr), 64'hx);
        end else begin
          we = wr_q.pop_front();
          chk("wr_addr", 64'(tpu_addr), 64'(we.a));
          chk("wr_data", tpu_wdata, we.d);
        end
        if (tpu_addr < 16'h300) begin
          chk("wr_ab_handshake", 64'(in_valid && in_ready), 64'd1);
          chk("wr_ab_data_is_input", tpu_wdata, in_data);
        end
        if (tpu_addr == 16'h400) begin
          go_arm = 1;
          go_cyc = cyc;
          act    = 0;
        end
      end
      // reads: new request, then address held for the read latency
      if (rd_hold > 0) begin
        chk("rd_addr_hold", {47'd0, tpu_r_w, tpu_addr}, {47'd0, 1'b0, rd_addr});
        rd_hold--;
      end else if (!tpu_r_w && tpu_addr != 16'h0) begin
        if (rd_q.size() == 0) chk("unexpected_read_addr", 64'(tpu_addr), 64'hx);
        else chk("rd_addr", 64'(tpu_addr), 64'(rd_q.pop_front()));
        rd_hold = RD_LAT;
        rd_addr = tpu_addr;
      end
    end
  end

  // ---------------- output consumer ----------------
  int bp_word    = -1;
  bit bp_done    = 0;
  int bp_hold    = 0;
  bit rand_ready = 0;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_hold > 0) begin
        out_ready = 1'b0;
        bp_hold--;
      end else if (out_valid && bp_word >= 0 && out_idx == bp_word && !bp_done) begin
        out_ready = 1'b0;
        bp_hold   = 4;
        bp_done   = 1;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_tpu_r_w"}, 64'(tpu_r_w), 64'd0);
    chk({tag, "_tpu_addr"}, 64'(tpu_addr), 64'd0);
    chk({tag, "_tpu_wdata"}, tpu_wdata, 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
  endtask

  task automatic recover();
    in_valid = 1'b0;
    start    = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    wr_q.delete();
    rd_q.delete();
  endtask

  task automatic run_job(input int kind, input bit stall, input bit bp, input bit rst3,
                         input bit start2, input bit sbusy, input bit gaps);
    logic [63:0] words[$];
    wr_t         e;
    int          d0;
    bit          hs, ok;
    for (int i = 0; i < 8; i++) begin
      ja[i] = (kind == 0) ? (64'h1 << (8 * i)) : {$urandom(), $urandom()};
      jb[i] = (kind == 0) ? {8{8'(i + 1)}} : {$urandom(), $urandom()};
    end
    for (int w = 0; w < 16; w++) begin
`ifdef TPU_HOST_C_PRELOAD_EN
      js[w] = (kind == 2) ? 64'h0001_0001_0001_0001 :
              (kind == 0) ? 64'h0 : {$urandom(), $urandom()};
`else
      js[w] = 64'h0;
`endif
    end
    exp_q.delete();
    wr_q.delete();
    rd_q.delete();
    for (int i = 0; i < 8; i++) begin
      words.push_back(ja[i]);
      e.a = 16'('h100 + 8 * i); e.d = ja[i]; wr_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      words.push_back(jb[i]);
      e.a = 16'('h200 + 8 * i); e.d = jb[i]; wr_q.push_back(e);
    end
    for (int w = 0; w < 16; w++) begin
`ifdef TPU_HOST_C_PRELOAD_EN
      words.push_back(js[w]);
`endif
      e.a = 16'('h300 + 8 * w); e.d = js[w]; wr_q.push_back(e);
    end
    e.a = 16'h400; e.d = 64'h0; wr_q.push_back(e);
    for (int w = 0; w < 16; w++) begin
      rd_q.push_back(16'('h300 + 8 * w));
      exp_q.push_back(ref_word(w));
    end

    bp_word    = bp ? 7 : -1;
    bp_done    = 0;
    rand_ready = gaps;

    ok = 0;
    for (int t = 0; t < 200; t++) begin
      if (!busy && !done) begin ok = 1; break; end
      @(posedge clk);
      #1;
    end
    if (!ok) begin chk("idle_timeout", 64'd0, 64'd1); recover(); return; end

    d0    = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_start", 64'(busy), 64'd1);
    if (start2) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    for (int n = 0; n < words.size(); n++) begin
      if (rst3 && n == 11) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check_idle("midjob_reset");
        rst_n = 1'b1;
        exp_q.delete();
        wr_q.delete();
        rd_q.delete();
        return;
      end
      if (stall && n == 12) begin
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom()};
        repeat (3) @(posedge clk);
        #1;
      end else if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom()};
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = words[n];
      ok = 0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk);
        #1;
        if (hs) begin ok = 1; break; end
      end
      in_valid = 1'b0;
      if (!ok) begin chk("in_handshake_timeout", 64'd0, 64'd1); recover(); return; end
    end

    if (sbusy) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end

    ok = 0;
    for (int t = 0; t < 4000; t++) begin
      @(posedge clk);
      #1;
      if (done_cnt != d0) begin ok = 1; break; end
    end
    if (!ok) begin chk("done_timeout", 64'd0, 64'd1); recover(); return; end
    repeat (6) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("out_words_left", 64'(exp_q.size()), 64'd0);
    chk("writes_left", 64'(wr_q.size()), 64'd0);
    chk("reads_left", 64'(rd_q.size()), 64'd0);
    chk("idle_after_job", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // kind, stall, bp, rst3, start2, sbusy, gaps
    run_job(0, 0, 0, 0, 0, 0, 0);
    run_job(1, 1, 1, 0, 0, 0, 0);
    run_job(1, 0, 0, 1, 0, 0, 0);
    run_job(1, 0, 0, 0, 1, 1, 0);
    run_job(2, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) run_job(1, 0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
